// File: rtl/fht_io_seq_pkg.sv
// Shared FHT definitions: default bank address and sample widths, the
// frame-length derivation and the I/O sequencer state encoding.
package fht_io_seq_pkg;

  // Default bank address width; one frame spans four banks of 2^A_BIT words.
  localparam int FHT_A_BIT = 8;
  // Default sample width.
  localparam int FHT_D_BIT = 16;

  // Frame length in samples for a given bank address width.
  function automatic int fht_frame_len(input int a_bit);
    return 32'sd4 << a_bit;
  endfunction

  // I/O sequencer states.
  typedef enum logic [2:0] {
    ST_LOAD      = 3'd0,
    ST_START     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_UNLOAD    = 3'd4
  } fht_io_state_e;

endpackage

// File: rtl/fht_io_seq_skid_buf.sv
// fht_skid_buf: 2-entry FIFO that absorbs read data returning from the bank
// RAM while the downstream consumer stalls.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   push, push_data     write one entry (caller guarantees not full)
//   pop                 drop the head entry (caller guarantees not empty)
//   head_data           current head entry
//   count               occupancy, 0..2
module fht_skid_buf #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic [1:0]   count
);

  logic [W-1:0] mem_r [2];
  logic         wr_ptr_r;
  logic         rd_ptr_r;
  logic [1:0]   cnt_r;

  // Storage, pointers and occupancy update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_r[0] <= {W{1'b0}};
      mem_r[1] <= {W{1'b0}};
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      cnt_r    <= 2'd0;
    end else begin
      if (push) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (pop) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({push, pop})
        2'b10:   cnt_r <= cnt_r + 2'd1;
        2'b01:   cnt_r <= cnt_r - 2'd1;
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  assign head_data = mem_r[rd_ptr_r];
  assign count     = cnt_r;

endmodule

// File: rtl/fht_io_seq.sv
// fht_io_seq: frame sequencer around the FHT core. Loads one frame of N
// samples into the four bank RAMs, pulses oSTART to the transform control,
// waits for it to go busy and then idle again, and streams the frame back
// out in natural index order.
// Ports:
//   iCLK, iRESET                         clock, async active-low reset
//   iDATA/iVALID/oREADY                  input sample stream
//   oWR_BANK/oWR_ADDR/oWR_DATA/oWE       bank RAM write port
//   oSTART/iRDY                          transform control handshake
//   oRD_BANK/oRD_ADDR/iRD_DATA           bank RAM read port (1-cycle latency)
//   oDATA/oVALID/oLAST/iREADY            result stream
//   oBUSY                                high whenever not loading
module fht_io_seq
  import fht_io_seq_pkg::*;
#(
  parameter int A_BIT = FHT_A_BIT,
  parameter int D_BIT = FHT_D_BIT
) (
  input  logic             iCLK,
  input  logic             iRESET,
  input  logic [D_BIT-1:0] iDATA,
  input  logic             iVALID,
  output logic             oREADY,
  output logic [1:0]       oWR_BANK,
  output logic [A_BIT-1:0] oWR_ADDR,
  output logic [D_BIT-1:0] oWR_DATA,
  output logic             oWE,
  output logic             oSTART,
  input  logic             iRDY,
  output logic [1:0]       oRD_BANK,
  output logic [A_BIT-1:0] oRD_ADDR,
  input  logic [D_BIT-1:0] iRD_DATA,
  output logic [D_BIT-1:0] oDATA,
  output logic             oVALID,
  output logic             oLAST,
  input  logic             iREADY,
  output logic             oBUSY
);

  localparam int N   = fht_frame_len(A_BIT);
  localparam int K_W = A_BIT + 2;
  localparam logic [K_W-1:0] LAST_IDX = K_W'(N - 1);
  localparam logic [K_W-1:0] ONE_IDX  = K_W'(1);

  fht_io_state_e  state_r;
  logic [K_W-1:0] wr_idx_r;
  logic [K_W-1:0] rd_idx_r;
  logic           issue_done_r;
  logic           inflight_r;
  logic           inflight_last_r;

  logic           accept_s;
  logic           issue_s;
  logic           pop_s;
  logic           buf_valid_s;
  logic [2:0]     pending_s;
  logic [1:0]     buf_cnt_s;
  logic [D_BIT:0] buf_head_s;

  // Handshake decode and read-issue throttle. A read may be issued when the
  // entries that will occupy the buffer next cycle (current occupancy plus
  // the read in flight, minus the entry leaving now) leave room for it.
  always_comb begin
    accept_s    = 1'b0;
    issue_s     = 1'b0;
    pop_s       = 1'b0;
    buf_valid_s = 1'b0;
    pending_s   = 3'd0;
    if (state_r == ST_LOAD) begin
      // Gating with iRESET keeps oWE low while reset is asserted.
      accept_s = iVALID & iRESET;
    end else begin
      accept_s = 1'b0;
    end
    if (state_r == ST_UNLOAD) begin
      buf_valid_s = (buf_cnt_s != 2'd0);
      pop_s       = buf_valid_s & iREADY;
      pending_s   = {1'b0, buf_cnt_s} + {2'b00, inflight_r} - {2'b00, pop_s};
      issue_s     = !issue_done_r && (pending_s < 3'd2);
    end else begin
      buf_valid_s = 1'b0;
      pop_s       = 1'b0;
      issue_s     = 1'b0;
    end
  end

  // Sequencer state, load/read counters and the read-in-flight tracker.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state_r         <= ST_LOAD;
      wr_idx_r        <= {K_W{1'b0}};
      rd_idx_r        <= {K_W{1'b0}};
      issue_done_r    <= 1'b0;
      inflight_r      <= 1'b0;
      inflight_last_r <= 1'b0;
    end else begin
      inflight_r      <= issue_s;
      inflight_last_r <= issue_s && (rd_idx_r == LAST_IDX);
      case (state_r)
        ST_LOAD: begin
          if (accept_s) begin
            // Counter wraps to 0 after the last sample of the frame.
            wr_idx_r <= wr_idx_r + ONE_IDX;
            if (wr_idx_r == LAST_IDX) begin
              state_r <= ST_START;
            end
          end
        end
        ST_START: begin
          state_r <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (!iRDY) begin
            state_r <= ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          if (iRDY) begin
            state_r <= ST_UNLOAD;
          end
        end
        ST_UNLOAD: begin
          if (issue_s) begin
            rd_idx_r <= rd_idx_r + ONE_IDX;
            if (rd_idx_r == LAST_IDX) begin
              issue_done_r <= 1'b1;
            end
          end
          // The last sample leaving the buffer ends the frame.
          if (pop_s && buf_head_s[D_BIT]) begin
            state_r      <= ST_LOAD;
            issue_done_r <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_LOAD;
        end
      endcase
    end
  end

  // Read data returns one cycle after issue, tagged with its last flag.
  fht_skid_buf #(
    .W(D_BIT + 1)
  ) u_skid_buf (
    .clk       (iCLK),
    .rst_n     (iRESET),
    .push      (inflight_r),
    .push_data ({inflight_last_r, iRD_DATA}),
    .pop       (pop_s),
    .head_data (buf_head_s),
    .count     (buf_cnt_s)
  );

  assign oREADY   = (state_r == ST_LOAD);
  assign oWE      = accept_s;
  assign oWR_BANK = wr_idx_r[1:0];
  assign oWR_ADDR = wr_idx_r[K_W-1:2];
  assign oWR_DATA = accept_s ? iDATA : {D_BIT{1'b0}};
  assign oSTART   = (state_r == ST_START);
  assign oRD_BANK = rd_idx_r[1:0];
  assign oRD_ADDR = rd_idx_r[K_W-1:2];
  assign oVALID   = buf_valid_s;
  assign oDATA    = buf_valid_s ? buf_head_s[D_BIT-1:0] : {D_BIT{1'b0}};
  assign oLAST    = buf_valid_s & buf_head_s[D_BIT];
  assign oBUSY    = (state_r != ST_LOAD);

endmodule
